poly_voice_alloc: RTL and testbench

- Parametrised polyphonic voice allocator and sample-rate voice scheduler.
- Accepts note-on/off events through a valid/ready handshake and keeps an internal table of NUM_VOICES voices.
- Allocates voices by retrigger, then free voice, then oldest releasing voice, then oldest voice (steal).
- On every sample tick, sweeps the table and streams per-voice parameters to the downstream oscillator/ADSR pipeline. Replaces fixed 32-slot, single-mode voice handling.

---
 rtl/poly_voice_alloc.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_poly_voice_alloc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_alloc.sv
// Polyphonic voice allocator: handshaked note events update a voice table; each tick sweeps it.
// SUSTAIN_PEDAL_EN adds the sustain pedal; POLY_VOICE_ALLOC_DEBUG exposes the lost-tick flag.
module poly_voice_alloc #(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned VIDX_W     = 4,
    parameter int unsigned AGE_W      = 12
) (
    input  logic                  clk32,
    input  logic                  rst,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [6:0]            ev_note,
    input  logic [6:0]            ev_vel,
    input  logic [3:0]            ev_chan,
    input  logic                  tick,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                  sustain,
`endif
    input  logic [NUM_VOICES-1:0] voice_idle,
    output logic                  vo_valid,
    output logic [VIDX_W-1:0]     vo_idx,
    output logic [6:0]            vo_note,
    output logic [6:0]            vo_vel,
    output logic [3:0]            vo_chan,
    output logic                  vo_gate,
    output logic                  vo_trig,
    output logic                  sweep_done,
    output logic [VIDX_W:0]       active_cnt,
`ifdef POLY_VOICE_ALLOC_DEBUG
    output logic                  dbg_tick_lost,
`endif
    output logic [7:0]            steal_cnt
);

    typedef enum logic [2:0] {StIdle, StScan, StCommit, StSweep, StRelease} state_e;

    localparam int unsigned       CntW    = VIDX_W + 1;
    localparam logic [VIDX_W-1:0] LastIdx = VIDX_W'(NUM_VOICES - 1);

    state_e                r_state;
    logic                  r_ev_ready;
    logic [VIDX_W-1:0]     r_idx;
    logic                  r_ev_on;
    logic [6:0]            r_ev_note;
    logic [6:0]            r_ev_vel;
    logic [3:0]            r_ev_chan;
    logic [6:0]            r_note  [NUM_VOICES];
    logic [6:0]            r_vel   [NUM_VOICES];
    logic [3:0]            r_chan  [NUM_VOICES];
    logic [AGE_W-1:0]      r_stamp [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active;
    logic [NUM_VOICES-1:0] r_gate;
    logic [NUM_VOICES-1:0] r_trig;
    logic [AGE_W-1:0]      r_stamp_now;
    logic                  r_tick_pending;
    logic                  r_sweep_done;
    logic [CntW-1:0]       r_active_cnt;
    logic [7:0]            r_steal_cnt;
`ifdef SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0] r_held;
    logic                  r_sus_q;
    logic                  r_rel_pending;
`endif

    // Scan trackers: retrigger match, note-off match, free, oldest releasing, oldest overall.
    logic                  r_m_found, r_off_found, r_f_found, r_r_found;
    logic [VIDX_W-1:0]     r_m_idx, r_off_idx, r_f_idx, r_r_idx, r_o_idx;
    logic [AGE_W-1:0]      r_r_age, r_o_age;

    logic                  w_hs;
    logic                  w_last;
    logic                  w_match;
    logic                  w_is_on;
    logic                  w_sweep_start;
    logic [AGE_W-1:0]      w_age;
    logic [VIDX_W-1:0]     w_tgt;
    logic                  w_steal;
    logic [CntW-1:0]       w_pop;

    assign w_hs          = ev_valid & r_ev_ready;
    assign w_last        = (r_idx == LastIdx);
    assign w_match       = r_active[r_idx] && (r_note[r_idx] == r_ev_note) &&
                           (r_chan[r_idx] == r_ev_chan);
    assign w_is_on       = r_ev_on && (r_ev_vel != 7'd0);
    assign w_sweep_start = (r_state == StIdle) && !w_hs && (tick || r_tick_pending);
    assign w_age         = r_stamp_now - r_stamp[r_idx];

    always_comb begin
        w_steal = 1'b0;
        if (r_m_found) begin
            w_tgt = r_m_idx;
        end else if (r_f_found) begin
            w_tgt = r_f_idx;
        end else if (r_r_found) begin
            w_tgt = r_r_idx;
        end else begin
            w_tgt   = r_o_idx;
            w_steal = 1'b1;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            w_pop = w_pop + CntW'(r_active[i]);
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            r_state        <= StIdle;
            r_ev_ready     <= 1'b0;
            r_idx          <= '0;
            r_ev_on        <= 1'b0;
            r_ev_note      <= '0;
            r_ev_vel       <= '0;
            r_ev_chan      <= '0;
            r_active       <= '0;
            r_gate         <= '0;
            r_trig         <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                r_note[i]  <= '0;
                r_vel[i]   <= '0;
                r_chan[i]  <= '0;
                r_stamp[i] <= '0;
            end
            r_stamp_now    <= '0;
            r_tick_pending <= 1'b0;
            r_sweep_done   <= 1'b0;
            r_active_cnt   <= '0;
            r_steal_cnt    <= '0;
            r_m_found      <= 1'b0;
            r_off_found    <= 1'b0;
            r_f_found      <= 1'b0;
            r_r_found      <= 1'b0;
            r_m_idx        <= '0;
            r_off_idx      <= '0;
            r_f_idx        <= '0;
            r_r_idx        <= '0;
            r_o_idx        <= '0;
            r_r_age        <= '0;
            r_o_age        <= '0;
`ifdef SUSTAIN_PEDAL_EN
            r_held         <= '0;
            r_sus_q        <= 1'b0;
            r_rel_pending  <= 1'b0;
`endif
        end else begin
            r_sweep_done <= 1'b0;
            r_active_cnt <= w_pop;
            // A tick that coincides with a pending-driven sweep start stays pending.
            if (w_sweep_start) begin
                r_tick_pending <= tick & r_tick_pending;
            end else if (tick) begin
                r_tick_pending <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_state     <= StScan;
                        r_ev_ready  <= 1'b0;
                        r_idx       <= '0;
                        r_ev_on     <= ev_on;
                        r_ev_note   <= ev_note;
                        r_ev_vel    <= ev_vel;
                        r_ev_chan   <= ev_chan;
                        r_m_found   <= 1'b0;
                        r_off_found <= 1'b0;
                        r_f_found   <= 1'b0;
                        r_r_found   <= 1'b0;
                    end else if (tick || r_tick_pending) begin
                        r_state    <= StSweep;
                        r_ev_ready <= 1'b0;
                        r_idx      <= '0;
`ifdef SUSTAIN_PEDAL_EN
                    end else if (r_rel_pending) begin
                        r_state       <= StRelease;
                        r_ev_ready    <= 1'b0;
                        r_idx         <= '0;
                        r_rel_pending <= 1'b0;
`endif
                    end else begin
                        r_ev_ready <= 1'b1;
                    end
                end

                StScan: begin
                    if (w_match && !r_m_found) begin
                        r_m_found <= 1'b1;
                        r_m_idx   <= r_idx;
                    end
                    if (w_match && r_gate[r_idx] && !r_off_found) begin
                        r_off_found <= 1'b1;
                        r_off_idx   <= r_idx;
                    end
                    if (!r_active[r_idx] && !r_f_found) begin
                        r_f_found <= 1'b1;
                        r_f_idx   <= r_idx;
                    end
                    if (r_active[r_idx] && !r_gate[r_idx] && (!r_r_found || w_age > r_r_age)) begin
                        r_r_found <= 1'b1;
                        r_r_idx   <= r_idx;
                        r_r_age   <= w_age;
                    end
                    if ((r_idx == '0) || (w_age > r_o_age)) begin
                        r_o_idx <= r_idx;
                        r_o_age <= w_age;
                    end
                    if (w_last) begin
                        r_state <= StCommit;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + VIDX_W'(1);
                    end
                end

                StCommit: begin
                    if (w_is_on) begin
                        r_note[w_tgt]   <= r_ev_note;
                        r_chan[w_tgt]   <= r_ev_chan;
                        r_vel[w_tgt]    <= r_ev_vel;
                        r_stamp[w_tgt]  <= r_stamp_now;
                        r_active[w_tgt] <= 1'b1;
                        r_gate[w_tgt]   <= 1'b1;
                        r_trig[w_tgt]   <= 1'b1;
                        r_stamp_now     <= r_stamp_now + AGE_W'(1);
`ifdef SUSTAIN_PEDAL_EN
                        r_held[w_tgt]   <= 1'b0;
`endif
                        if (w_steal && (r_steal_cnt != 8'hFF)) begin
                            r_steal_cnt <= r_steal_cnt + 8'd1;
                        end
                    end else if (r_off_found) begin
`ifdef SUSTAIN_PEDAL_EN
                        if (sustain) begin
                            r_held[r_off_idx] <= 1'b1;
                        end else begin
                            r_gate[r_off_idx] <= 1'b0;
                        end
`else
                        r_gate[r_off_idx] <= 1'b0;
`endif
                    end
                    r_state    <= StIdle;
                    r_ev_ready <= 1'b1;
                end

                StSweep: begin
                    r_trig[r_idx] <= 1'b0;
                    if (voice_idle[r_idx] && !r_gate[r_idx]) begin
                        r_active[r_idx] <= 1'b0;
                    end
                    if (w_last) begin
                        r_state      <= StIdle;
                        r_ev_ready   <= 1'b1;
                        r_sweep_done <= 1'b1;
                        r_idx        <= '0;
                    end else begin
                        r_idx <= r_idx + VIDX_W'(1);
                    end
                end

`ifdef SUSTAIN_PEDAL_EN
                StRelease: begin
                    if (r_held[r_idx]) begin
                        r_gate[r_idx] <= 1'b0;
                        r_held[r_idx] <= 1'b0;
                    end
                    if (w_last) begin
                        r_state    <= StIdle;
                        r_ev_ready <= 1'b1;
                        r_idx      <= '0;
                    end else begin
                        r_idx <= r_idx + VIDX_W'(1);
                    end
                end
`endif

                default: begin
                    r_state    <= StIdle;
                    r_ev_ready <= 1'b0;
                end
            endcase

`ifdef SUSTAIN_PEDAL_EN
            r_sus_q <= sustain;
            if (r_sus_q && !sustain) begin
                r_rel_pending <= 1'b1;
            end
`endif
        end
    end

`ifdef POLY_VOICE_ALLOC_DEBUG
    logic r_tick_lost;
    always_ff @(posedge clk32) begin
        if (rst) begin
            r_tick_lost <= 1'b0;
        end else if (tick && r_tick_pending && !w_sweep_start) begin
            r_tick_lost <= 1'b1;
        end
    end
    assign dbg_tick_lost = r_tick_lost;
`endif

    assign ev_ready   = r_ev_ready;
    assign vo_valid   = (r_state == StSweep);
    assign sweep_done = r_sweep_done;
    assign active_cnt = r_active_cnt;
    assign steal_cnt  = r_steal_cnt;

    // Inactive slots still emit a record, but with all parameters forced to zero.
    always_comb begin
        vo_idx  = '0;
        vo_note = '0;
        vo_vel  = '0;
        vo_chan = '0;
        vo_gate = 1'b0;
        vo_trig = 1'b0;
        if (vo_valid) begin
            vo_idx = r_idx;
            if (r_active[r_idx]) begin
                vo_note = r_note[r_idx];
                vo_vel  = r_vel[r_idx];
                vo_chan = r_chan[r_idx];
                vo_gate = r_gate[r_idx];
                vo_trig = r_trig[r_idx];
            end
        end
    end

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Bench for poly_voice_alloc (4 voices): directed vector table, timing corner sequences and
// randomized events compared against a behavioural allocation model.
module tb_poly_voice_alloc;

    localparam int unsigned N  = 4;
    localparam int unsigned VW = 2;
    localparam int unsigned AW = 12;

    logic          clk32 = 1'b0;
    logic          rst;
    logic          ev_valid;
    logic          ev_ready;
    logic          ev_on;
    logic [6:0]    ev_note;
    logic [6:0]    ev_vel;
    logic [3:0]    ev_chan;
    logic          tick;
`ifdef SUSTAIN_PEDAL_EN
    logic          sustain;
`endif
    logic [N-1:0]  voice_idle;
    logic          vo_valid;
    logic [VW-1:0] vo_idx;
    logic [6:0]    vo_note;
    logic [6:0]    vo_vel;
    logic [3:0]    vo_chan;
    logic          vo_gate;
    logic          vo_trig;
    logic          sweep_done;
    logic [VW:0]   active_cnt;
    logic [7:0]    steal_cnt;

    always #5 clk32 = ~clk32;

    poly_voice_alloc #(
        .NUM_VOICES (N),
        .VIDX_W     (VW),
        .AGE_W      (AW)
    ) dut (
        .clk32      (clk32),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .ev_chan    (ev_chan),
        .tick       (tick),
`ifdef SUSTAIN_PEDAL_EN
        .sustain    (sustain),
`endif
        .voice_idle (voice_idle),
        .vo_valid   (vo_valid),
        .vo_idx     (vo_idx),
        .vo_note    (vo_note),
        .vo_vel     (vo_vel),
        .vo_chan    (vo_chan),
        .vo_gate    (vo_gate),
        .vo_trig    (vo_trig),
        .sweep_done (sweep_done),
        .active_cnt (active_cnt),
        .steal_cnt  (steal_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: allocation order is a plain sequence number, smaller means older.
    bit m_active [N];
    bit m_gate   [N];
    bit m_trig   [N];
    int m_note   [N];
    int m_vel    [N];
    int m_chan   [N];
    int m_seq    [N];
    int m_next_seq;
    int m_steals;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0; m_gate[i] = 0; m_trig[i] = 0;
            m_note[i] = 0; m_vel[i] = 0; m_chan[i] = 0; m_seq[i] = 0;
        end
        m_next_seq = 1;
        m_steals   = 0;
    endfunction

    function automatic void model_event(input bit on, input int note, input int vel, input int chan);
        int tgt;
        tgt = -1;
        if (on && vel != 0) begin
            for (int i = 0; i < N; i++)
                if (tgt < 0 && m_active[i] && m_note[i] == note && m_chan[i] == chan) tgt = i;
            for (int i = 0; i < N; i++)
                if (tgt < 0 && !m_active[i]) tgt = i;
            if (tgt < 0)
                for (int i = 0; i < N; i++)
                    if (m_active[i] && !m_gate[i] && (tgt < 0 || m_seq[i] < m_seq[tgt])) tgt = i;
            if (tgt < 0) begin
                for (int i = 0; i < N; i++)
                    if (tgt < 0 || m_seq[i] < m_seq[tgt]) tgt = i;
                if (m_steals < 255) m_steals++;
            end
            m_note[tgt] = note; m_vel[tgt] = vel; m_chan[tgt] = chan;
            m_active[tgt] = 1; m_gate[tgt] = 1; m_trig[tgt] = 1;
            m_seq[tgt] = m_next_seq;
            m_next_seq++;
        end else begin
            for (int i = 0; i < N; i++)
                if (tgt < 0 && m_active[i] && m_gate[i] && m_note[i] == note && m_chan[i] == chan)
                    tgt = i;
            if (tgt >= 0) m_gate[tgt] = 0;
        end
    endfunction

    function automatic void model_sweep(input logic [N-1:0] idle);
        for (int i = 0; i < N; i++) begin
            m_trig[i] = 0;
            if (idle[i] && !m_gate[i]) m_active[i] = 0;
        end
    endfunction

    function automatic int model_active();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(m_active[i]);
        return c;
    endfunction

    function automatic logic [22:0] model_rec(input int i);
        if (m_active[i])
            return {1'b1, VW'(i), 7'(m_note[i]), 7'(m_vel[i]), 4'(m_chan[i]), m_gate[i], m_trig[i]};
        return {1'b1, VW'(i), 7'd0, 7'd0, 4'd0, 1'b0, 1'b0};
    endfunction

    function automatic logic [22:0] dut_rec();
        return {vo_valid, vo_idx, vo_note, vo_vel, vo_chan, vo_gate, vo_trig};
    endfunction

    logic [6:0] rec_note [N];
    logic       rec_gate [N];
    logic       rec_trig [N];

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ev_ready && n < 100) begin
            @(posedge clk32); #1;
            n++;
        end
        check(name, 32'(ev_ready), 32'd1);
    endtask

    task automatic send_event(input bit on, input int note, input int vel, input int chan);
        wait_ready("ev_ready_wait");
        ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_vel = 7'(vel); ev_chan = 4'(chan);
        @(posedge clk32); #1;
        ev_valid = 1'b0;
        model_event(on, note, vel, chan);
    endtask

    // Called with the first record already on the outputs.
    task automatic collect_records(input logic [N-1:0] idle, input bit use_model);
        for (int k = 0; k < N; k++) begin
            rec_note[k] = vo_note; rec_gate[k] = vo_gate; rec_trig[k] = vo_trig;
            if (use_model) check($sformatf("sweep_rec%0d", k), 32'(dut_rec()), 32'(model_rec(k)));
            else check($sformatf("sweep_idx%0d", k), 32'({vo_valid, vo_idx}), 32'({1'b1, VW'(k)}));
            @(posedge clk32); #1;
        end
        check("sweep_done", 32'({sweep_done, vo_valid}), 32'b10);
        if (use_model) model_sweep(idle);
        @(posedge clk32); #1;
        if (use_model) begin
            check("active_cnt", 32'(active_cnt), 32'(model_active()));
            check("steal_cnt", 32'(steal_cnt), 32'(m_steals));
        end
        voice_idle = '0;
    endtask

    task automatic run_sweep(input logic [N-1:0] idle, input bit use_model);
        wait_ready("sweep_wait_idle");
        voice_idle = idle;
        tick = 1'b1;
        @(posedge clk32); #1;
        tick = 1'b0;
        collect_records(idle, use_model);
    endtask

    typedef struct {
        bit           has_ev;
        bit           on;
        int           note;
        int           vel;
        int           chan;
        logic [N-1:0] idle;
        int           exp_idx;
        int           exp_note;
        bit           exp_gate;
        bit           exp_trig;
        int           exp_steal;
        int           exp_act;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n;
        vecs[0]  = '{1, 1, 60, 100, 0, 4'b0000, 0, 60, 1, 1, 0, 1};
        vecs[1]  = '{0, 0,  0,   0, 0, 4'b0000, 0, 60, 1, 0, 0, 1};
        vecs[2]  = '{1, 1, 62, 100, 0, 4'b0000, 1, 62, 1, 1, 0, 2};
        vecs[3]  = '{1, 1, 64, 100, 0, 4'b0000, 2, 64, 1, 1, 0, 3};
        vecs[4]  = '{1, 1, 65, 100, 0, 4'b0000, 3, 65, 1, 1, 0, 4};
        vecs[5]  = '{1, 1, 67, 100, 0, 4'b0000, 0, 67, 1, 1, 1, 4};
        vecs[6]  = '{1, 0, 62,  64, 0, 4'b0000, 1, 62, 0, 0, 1, 4};
        vecs[7]  = '{1, 1, 70, 100, 0, 4'b0000, 1, 70, 1, 1, 1, 4};
        vecs[8]  = '{1, 0, 61,  64, 0, 4'b0000, 0, 67, 1, 0, 1, 4};
        vecs[9]  = '{1, 1, 64,   0, 0, 4'b0000, 2, 64, 0, 0, 1, 4};
        vecs[10] = '{0, 0,  0,   0, 0, 4'b0100, 2, 64, 0, 0, 1, 3};
        vecs[11] = '{0, 0,  0,   0, 0, 4'b0000, 2,  0, 0, 0, 1, 3};

        rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_vel = '0; ev_chan = '0;
        tick = 1'b0; voice_idle = '0;
`ifdef SUSTAIN_PEDAL_EN
        sustain = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk32);
        #1;
        check("rst_ev_ready", 32'(ev_ready), 32'd0);
        check("rst_outputs", 32'({vo_valid, sweep_done, active_cnt, steal_cnt}), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk32);
        #1;
        check("post_rst_ev_ready", 32'(ev_ready), 32'd1);

        for (int r = 0; r < 12; r++) begin
            if (vecs[r].has_ev) send_event(vecs[r].on, vecs[r].note, vecs[r].vel, vecs[r].chan);
            run_sweep(vecs[r].idle, 1'b1);
            check($sformatf("vec%0d_slot", r),
                  32'({rec_note[vecs[r].exp_idx], rec_gate[vecs[r].exp_idx], rec_trig[vecs[r].exp_idx]}),
                  32'({7'(vecs[r].exp_note), vecs[r].exp_gate, vecs[r].exp_trig}));
            check($sformatf("vec%0d_steal", r), 32'(steal_cnt), 32'(vecs[r].exp_steal));
            check($sformatf("vec%0d_active", r), 32'(active_cnt), 32'(vecs[r].exp_act));
        end

        // Event and tick in the same cycle: event commits first, sweep follows.
        wait_ready("tick_ev_wait");
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd72; ev_vel = 7'd90; ev_chan = 4'd3;
        tick = 1'b1;
        @(posedge clk32); #1;
        ev_valid = 1'b0; tick = 1'b0;
        model_event(1'b1, 72, 90, 3);
        n = 0;
        while (!vo_valid && n < 50) begin
            @(posedge clk32); #1;
            n++;
        end
        check("tick_ev_latency", 32'(n), 32'(N + 2));
        collect_records('0, 1'b1);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                bit on;
                int note, vel, chan;
                on   = ($urandom_range(0, 3) != 0);
                note = 60 + int'($urandom_range(0, 7));
                chan = int'($urandom_range(0, 1));
                vel  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
                send_event(on, note, vel, chan);
            end else begin
                run_sweep(N'($urandom), 1'b1);
            end
        end
        run_sweep('0, 1'b1);

        // Reset in the middle of a sweep aborts it.
        wait_ready("rst_sweep_wait");
        tick = 1'b1;
        @(posedge clk32); #1;
        tick = 1'b0;
        @(posedge clk32); #1;
        rst = 1'b1;
        @(posedge clk32); #1;
        rst = 1'b0;
        check("rst_mid_sweep_valid", 32'(vo_valid), 32'd0);
        model_reset();
        repeat (2) @(posedge clk32);
        #1;
        check("rst_mid_sweep_cnts", 32'({active_cnt, steal_cnt}), 32'd0);
        run_sweep('0, 1'b1);

`ifdef SUSTAIN_PEDAL_EN
        sustain = 1'b1;
        send_event(1'b1, 60, 100, 0);
        send_event(1'b0, 60, 0, 0);
        run_sweep('0, 1'b0);
        check("sus_gate_held", 32'({rec_note[0], rec_gate[0]}), 32'({7'd60, 1'b1}));
        sustain = 1'b0;
        repeat (2) @(posedge clk32);
        #1;
        run_sweep('0, 1'b0);
        check("sus_gate_released", 32'({rec_note[0], rec_gate[0]}), 32'({7'd60, 1'b0}));
        check("sus_active_before", 32'(active_cnt), 32'd1);
        run_sweep(4'b0001, 1'b0);
        check("sus_active_after", 32'(active_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
